vtg_mode_timing: RTL

//  Parametrised, run-time reprogrammable video timing generator for the HDMI TX path.

---
 rtl/vtg_mode_timing.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vtg_mode_timing.sv
// Reprogrammable video timing generator: counters, blanking, sync and DE.
// New modes are shadowed and swapped in only on a frame boundary or restart.
module vtg_mode_timing #(
  parameter int          CW      = 12,
  parameter int          DLY     = 2,
  parameter int unsigned DEF_HSB = 1919,
  parameter int unsigned DEF_HSS = 2007,
  parameter int unsigned DEF_HES = 2051,
  parameter int unsigned DEF_HEB = 2199,
  parameter int unsigned DEF_VSB = 1079,
  parameter int unsigned DEF_VSS = 1083,
  parameter int unsigned DEF_VES = 1088,
  parameter int unsigned DEF_VEB = 1124,
  parameter bit          DEF_POL = 1'b0
) (
  input  logic          pclk,
  input  logic          rst_,
  input  logic          restart,
  input  logic          mode_load,
  input  logic [CW-1:0] tc_hsblnk,
  input  logic [CW-1:0] tc_hssync,
  input  logic [CW-1:0] tc_hesync,
  input  logic [CW-1:0] tc_heblnk,
  input  logic [CW-1:0] tc_vsblnk,
  input  logic [CW-1:0] tc_vssync,
  input  logic [CW-1:0] tc_vesync,
  input  logic [CW-1:0] tc_veblnk,
  input  logic          pol,
  output logic          mode_busy,
  output logic          mode_done,
  output logic          mode_err,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hblnk,
  output logic          vblnk,
  output logic          frame_start,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o
);

  typedef struct packed {
    logic [CW-1:0] hsb;
    logic [CW-1:0] hss;
    logic [CW-1:0] hes;
    logic [CW-1:0] heb;
    logic [CW-1:0] vsb;
    logic [CW-1:0] vss;
    logic [CW-1:0] ves;
    logic [CW-1:0] veb;
    logic          pol;
  } tset_t;

  typedef enum logic {IDLE, PEND} st_t;

  tset_t dflt;
  tset_t ld;
  tset_t act;
  tset_t pnd;
  st_t   st;

  logic          ld_ok;
  logic          h_end;
  logic          v_end;
  logic          wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hs_int;
  logic          vs_int;
  logic [2:0]    dly_q [DLY];

  assign dflt = '{
    hsb: CW'(DEF_HSB),
    hss: CW'(DEF_HSS),
    hes: CW'(DEF_HES),
    heb: CW'(DEF_HEB),
    vsb: CW'(DEF_VSB),
    vss: CW'(DEF_VSS),
    ves: CW'(DEF_VES),
    veb: CW'(DEF_VEB),
    pol: DEF_POL
  };

  assign ld = '{
    hsb: tc_hsblnk,
    hss: tc_hssync,
    hes: tc_hesync,
    heb: tc_heblnk,
    vsb: tc_vsblnk,
    vss: tc_vssync,
    ves: tc_vesync,
    veb: tc_veblnk,
    pol: pol
  };

  assign ld_ok = (ld.hsb < ld.hss) &&
                 (ld.hss < ld.hes) &&
                 (ld.hes <= ld.heb) &&
                 (ld.vsb < ld.vss) &&
                 (ld.vss < ld.ves) &&
                 (ld.ves <= ld.veb);

  assign h_end = (hcount == act.heb);
  assign v_end = (vcount == act.veb);
  assign wrap  = h_end && v_end;

  always_comb begin
    h_nxt = hcount + 1'b1;
    v_nxt = vcount;
    if (restart) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_end) begin
      h_nxt = '0;
      v_nxt = v_end ? '0 : vcount + 1'b1;
    end
  end

  // Flags are computed from the next count so they land with it.
  // At (0,0) every flag is inactive for any legal set.
  always_ff @(posedge pclk) begin
    if (!rst_) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hs_int      <= 1'b0;
      vs_int      <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_nxt > act.hsb);
      vblnk       <= (v_nxt > act.vsb);
      hs_int      <= (h_nxt > act.hss) && (h_nxt <= act.hes);
      vs_int      <= (v_nxt > act.vss) && (v_nxt <= act.ves);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_) begin
      st        <= IDLE;
      act       <= dflt;
      pnd       <= '0;
      mode_busy <= 1'b0;
      mode_done <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      mode_done <= 1'b0;
      mode_err  <= 1'b0;
      unique case (st)
        IDLE: begin
          if (mode_load) begin
            if (ld_ok) begin
              pnd       <= ld;
              mode_busy <= 1'b1;
              st        <= PEND;
            end else begin
              mode_err  <= 1'b1;
            end
          end
        end
        PEND: begin
          if (wrap || restart) begin
            act       <= pnd;
            mode_busy <= 1'b0;
            mode_done <= 1'b1;
            st        <= IDLE;
          end
        end
      endcase
    end
  end

  // Polarity is folded in at the head so each tap carries final levels.
  always_ff @(posedge pclk) begin
    if (!rst_) begin
      for (int i = 0; i < DLY; i++) begin
        dly_q[i] <= {DEF_POL, DEF_POL, 1'b0};
      end
    end else begin
      dly_q[0] <= {hs_int ^ act.pol,
                   vs_int ^ act.pol,
                   !hblnk && !vblnk};
      for (int i = 1; i < DLY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign {hsync_o, vsync_o, de_o} = dly_q[DLY-1];

endmodule
